// File: rtl/cva6_clic_irq_sender.sv
// rtl/cva6_clic_irq_sender.sv - CLIC-side interrupt transmitter: pending tracking, arbitration, valid/ready/kill handshake.
// Presents the highest-ranked enabled pending source and holds it until accepted or withdrawn.
module cva6_clic_irq_sender #(
  parameter int unsigned NumSrc  = 64,
  parameter int unsigned IdWidth = $clog2(NumSrc)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NumSrc-1:0]     src_i,
  input  logic [NumSrc-1:0]     ie_i,
  input  logic [NumSrc-1:0]     edge_i,
  input  logic [NumSrc*8-1:0]   level_i,
  input  logic [NumSrc*2-1:0]   priv_i,
  output logic                  irq_valid_o,
  input  logic                  irq_ready_i,
  output logic [IdWidth-1:0]    irq_id_o,
  output logic [7:0]            irq_level_o,
  output logic [1:0]            irq_priv_o,
  output logic                  kill_req_o,
  input  logic                  kill_ack_i
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StValid  = 2'd1;
  localparam logic [1:0] StKill   = 2'd2;
  localparam logic [1:0] StSettle = 2'd3;

  logic [NumSrc-1:0]  src_q, src_d;
  logic [NumSrc-1:0]  pend_q, pend_d;
  logic               cand_valid_q, cand_valid_d;
  logic [IdWidth-1:0] cand_id_q, cand_id_d;
  logic [7:0]         cand_level_q, cand_level_d;
  logic [1:0]         cand_priv_q, cand_priv_d;
  logic [1:0]         state_q, state_d;
  logic               irq_valid_q, irq_valid_d;
  logic               kill_req_q, kill_req_d;
  logic [IdWidth-1:0] irq_id_q, irq_id_d;
  logic [7:0]         irq_level_q, irq_level_d;
  logic [1:0]         irq_priv_q, irq_priv_d;

  logic               accept;
  logic [NumSrc-1:0]  eligible;
  logic [9:0]         best_key, src_key;

  assign accept   = irq_valid_q & irq_ready_i;
  assign eligible = pend_q & ie_i;

  // Edge sources: a new rising edge beats a simultaneous accept-clear.
  always_comb begin
    src_d  = src_i;
    pend_d = pend_q;
    for (int unsigned i = 0; i < NumSrc; i++) begin
      if (edge_i[i]) begin
        if (accept && irq_id_q == IdWidth'(i)) pend_d[i] = 1'b0;
        if (src_i[i] && !src_q[i])             pend_d[i] = 1'b1;
      end else begin
        pend_d[i] = src_i[i];
      end
    end
  end

  // Strictly-greater compare while scanning upward keeps ties on the lowest id.
  always_comb begin
    cand_valid_d = 1'b0;
    cand_id_d    = '0;
    cand_level_d = '0;
    cand_priv_d  = '0;
    best_key     = '0;
    src_key      = '0;
    for (int unsigned i = 0; i < NumSrc; i++) begin
      src_key = {priv_i[2*i +: 2], level_i[8*i +: 8]};
      if (eligible[i] && (!cand_valid_d || src_key > best_key)) begin
        cand_valid_d = 1'b1;
        cand_id_d    = IdWidth'(i);
        cand_level_d = level_i[8*i +: 8];
        cand_priv_d  = priv_i[2*i +: 2];
        best_key     = src_key;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    irq_valid_d = irq_valid_q;
    kill_req_d  = kill_req_q;
    irq_id_d    = irq_id_q;
    irq_level_d = irq_level_q;
    irq_priv_d  = irq_priv_q;
    case (state_q)
      StIdle: begin
        if (cand_valid_q) begin
          irq_valid_d = 1'b1;
          irq_id_d    = cand_id_q;
          irq_level_d = cand_level_q;
          irq_priv_d  = cand_priv_q;
          state_d     = StValid;
        end
      end
      StValid: begin
        if (irq_ready_i) begin
          irq_valid_d = 1'b0;
          state_d     = StSettle;
        end else if (!eligible[irq_id_q] ||
                     (cand_valid_q && {cand_priv_q, cand_level_q} > {irq_priv_q, irq_level_q})) begin
          kill_req_d = 1'b1;
          state_d    = StKill;
        end
      end
      StKill: begin
        if (irq_ready_i || kill_ack_i) begin
          irq_valid_d = 1'b0;
          kill_req_d  = 1'b0;
          state_d     = StSettle;
        end
      end
      // One low cycle lets the candidate registers see the cleared pending bit.
      StSettle: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q        <= '0;
      pend_q       <= '0;
      cand_valid_q <= 1'b0;
      cand_id_q    <= '0;
      cand_level_q <= '0;
      cand_priv_q  <= '0;
      state_q      <= StIdle;
      irq_valid_q  <= 1'b0;
      kill_req_q   <= 1'b0;
      irq_id_q     <= '0;
      irq_level_q  <= '0;
      irq_priv_q   <= '0;
    end else begin
      src_q        <= src_d;
      pend_q       <= pend_d;
      cand_valid_q <= cand_valid_d;
      cand_id_q    <= cand_id_d;
      cand_level_q <= cand_level_d;
      cand_priv_q  <= cand_priv_d;
      state_q      <= state_d;
      irq_valid_q  <= irq_valid_d;
      kill_req_q   <= kill_req_d;
      irq_id_q     <= irq_id_d;
      irq_level_q  <= irq_level_d;
      irq_priv_q   <= irq_priv_d;
    end
  end

  assign irq_valid_o = irq_valid_q;
  assign kill_req_o  = kill_req_q;
  assign irq_id_o    = irq_id_q;
  assign irq_level_o = irq_level_q;
  assign irq_priv_o  = irq_priv_q;

endmodule

// File: tb/tb_cva6_clic_irq_sender.sv
// tb/tb_cva6_clic_irq_sender.sv - self-checking bench for cva6_clic_irq_sender.
// Directed vector table, hand-written handshake sequences, then random stimulus against a reference model.
module tb_cva6_clic_irq_sender;
  localparam int N = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  src, ie, edg;
  logic [N*8-1:0] lvl;
  logic [N*2-1:0] pr;
  logic          ready, ack;
  logic          valid, kill;
  logic [IW-1:0] id;
  logic [7:0]    olvl;
  logic [1:0]    opr;

  int n_chk = 0;
  int n_err = 0;

  cva6_clic_irq_sender #(.NumSrc(N), .IdWidth(IW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .src_i(src), .ie_i(ie), .edge_i(edg),
    .level_i(lvl), .priv_i(pr), .irq_valid_o(valid), .irq_ready_i(ready),
    .irq_id_o(id), .irq_level_o(olvl), .irq_priv_o(opr),
    .kill_req_o(kill), .kill_ack_i(ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [N-1:0] src;
    bit          rdy;
    bit          ack;
    int          exp;
  } vec_t;
  vec_t tbl[$];

  // Reference model: pending set, candidate from last cycle, presentation with a low-cycle counter.
  logic [N-1:0] m_pend, m_srcq;
  bit m_cv, m_v, m_k, model_on;
  int m_cid, m_ckey, m_id, m_lvl, m_pr, m_low;

  function automatic int pack(bit v, bit k, int i, int l, int p);
    return (int'(v) << 15) | (int'(k) << 14) | ((i & 15) << 10) | ((l & 255) << 2) | (p & 3);
  endfunction

  function automatic int dut_pack();
    return pack(valid, kill, int'(id), int'(olvl), int'(opr));
  endfunction

  function automatic vec_t mk(string nm, logic [N-1:0] s, bit r, bit a, int e);
    vec_t v;
    v.name = nm; v.src = s; v.rdy = r; v.ack = a; v.exp = e;
    return v;
  endfunction

  task automatic chk(string nm, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%04h expected=%04h", nm, got, exp);
    end
  endtask

  task automatic cfg(int i, bit e, bit en, int l, int p);
    edg[i] = e;
    ie[i]  = en;
    lvl[8*i +: 8] = 8'(l);
    pr[2*i +: 2]  = 2'(p);
  endtask

  task automatic model_reset();
    m_pend = '0; m_srcq = '0; m_cv = 0; m_cid = 0; m_ckey = 0;
    m_v = 0; m_k = 0; m_id = 0; m_lvl = 0; m_pr = 0; m_low = 1;
  endtask

  task automatic model_step();
    bit acc, bv, nv, nk;
    int bid, bkey, k, nid, nl, np, nlow;
    logic [N-1:0] npend;
    acc = m_v && ready;
    bv = 0; bid = 0; bkey = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(pr[2*i +: 2]) * 256 + int'(lvl[8*i +: 8]);
      if (m_pend[i] && ie[i] && (!bv || k > bkey)) begin
        bv = 1; bid = i; bkey = k;
      end
    end
    nv = m_v; nk = m_k; nid = m_id; nl = m_lvl; np = m_pr; nlow = m_low;
    if (!m_v) begin
      if (m_low >= 1 && m_cv) begin
        nv = 1; nid = m_cid; nl = m_ckey % 256; np = m_ckey / 256;
      end else begin
        nlow = m_low + 1;
      end
    end else if (!m_k) begin
      if (ready) begin
        nv = 0; nlow = 0;
      end else if (!(m_pend[m_id] && ie[m_id]) || (m_cv && m_ckey > m_pr * 256 + m_lvl)) begin
        nk = 1;
      end
    end else if (ready || ack) begin
      nv = 0; nk = 0; nlow = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (!edg[i])                    npend[i] = src[i];
      else if (src[i] && !m_srcq[i])  npend[i] = 1'b1;
      else if (acc && m_id == i)      npend[i] = 1'b0;
      else                            npend[i] = m_pend[i];
    end
    m_pend = npend; m_srcq = src;
    m_cv = bv; m_cid = bid; m_ckey = bkey;
    m_v = nv; m_k = nk; m_id = nid; m_lvl = nl; m_pr = np; m_low = nlow;
  endtask

  task automatic tick();
    if (model_on) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [N-1:0] s, bit r, bit a);
    src = s; ready = r; ack = a;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Presents src 3, then pulses src 7 until the kill request is raised.
  task automatic reach_kill(string nm);
    drive(16'h0008, 0, 0); tick();
    drive(16'h0000, 0, 0); ticks(2);
    chk({nm, "_pres3"}, dut_pack(), pack(1, 0, 3, 8'h20, 3));
    drive(16'h0080, 0, 0); tick();
    drive(16'h0000, 0, 0); tick();
    chk({nm, "_nokill_yet"}, dut_pack(), pack(1, 0, 3, 8'h20, 3));
    tick();
    chk({nm, "_kill"}, dut_pack(), pack(1, 1, 3, 8'h20, 3));
  endtask

  initial begin
    model_on = 0;
    rst_n = 0; src = '0; ie = '0; edg = '0; lvl = '0; pr = '0; ready = 0; ack = 0;
    cfg(2, 1, 1, 8'h55, 3);
    cfg(3, 1, 1, 8'h20, 3);
    cfg(4, 0, 1, 8'h30, 3);
    cfg(5, 1, 1, 8'h40, 3);
    cfg(7, 1, 1, 8'h80, 3);
    cfg(9, 1, 1, 8'h55, 3);
    cfg(10, 1, 1, 8'hFF, 1);
    cfg(11, 1, 1, 8'h01, 3);
    ticks(2);
    chk("reset_state", dut_pack(), pack(0, 0, 0, 0, 0));
    rst_n = 1;

    tbl.push_back(mk("t1_pulse",  16'h0020, 0, 0, pack(0, 0, 0, 0, 0)));
    tbl.push_back(mk("t1_lat",    16'h0000, 0, 0, pack(0, 0, 0, 0, 0)));
    tbl.push_back(mk("t1_pres",   16'h0000, 0, 0, pack(1, 0, 5, 8'h40, 3)));
    tbl.push_back(mk("t1_hold",   16'h0000, 0, 0, pack(1, 0, 5, 8'h40, 3)));
    tbl.push_back(mk("t1_acc",    16'h0000, 1, 0, pack(0, 0, 5, 8'h40, 3)));
    tbl.push_back(mk("t1_gap1",   16'h0000, 0, 0, pack(0, 0, 5, 8'h40, 3)));
    tbl.push_back(mk("t1_gap2",   16'h0000, 0, 0, pack(0, 0, 5, 8'h40, 3)));
    tbl.push_back(mk("t1_gap3",   16'h0000, 0, 0, pack(0, 0, 5, 8'h40, 3)));
    tbl.push_back(mk("t4_pulse",  16'h0204, 0, 0, pack(0, 0, 5, 8'h40, 3)));
    tbl.push_back(mk("t4_lat",    16'h0000, 0, 0, pack(0, 0, 5, 8'h40, 3)));
    tbl.push_back(mk("t4_pres2",  16'h0000, 0, 0, pack(1, 0, 2, 8'h55, 3)));
    tbl.push_back(mk("t4_acc2",   16'h0000, 1, 0, pack(0, 0, 2, 8'h55, 3)));
    tbl.push_back(mk("t4_settle", 16'h0000, 0, 0, pack(0, 0, 2, 8'h55, 3)));
    tbl.push_back(mk("t4_pres9",  16'h0000, 0, 0, pack(1, 0, 9, 8'h55, 3)));
    tbl.push_back(mk("t4_acc9",   16'h0000, 1, 0, pack(0, 0, 9, 8'h55, 3)));
    tbl.push_back(mk("t4_gap",    16'h0000, 0, 0, pack(0, 0, 9, 8'h55, 3)));
    tbl.push_back(mk("t4_pulse2", 16'h0C00, 0, 0, pack(0, 0, 9, 8'h55, 3)));
    tbl.push_back(mk("t4_lat2",   16'h0000, 0, 0, pack(0, 0, 9, 8'h55, 3)));
    tbl.push_back(mk("t4_presM",  16'h0000, 0, 0, pack(1, 0, 11, 8'h01, 3)));
    tbl.push_back(mk("t4_accM",   16'h0000, 1, 0, pack(0, 0, 11, 8'h01, 3)));
    tbl.push_back(mk("t4_settle2",16'h0000, 0, 0, pack(0, 0, 11, 8'h01, 3)));
    tbl.push_back(mk("t4_presS",  16'h0000, 0, 0, pack(1, 0, 10, 8'hFF, 1)));
    tbl.push_back(mk("t4_accS",   16'h0000, 1, 0, pack(0, 0, 10, 8'hFF, 1)));
    tbl.push_back(mk("t4_idle",   16'h0000, 0, 0, pack(0, 0, 10, 8'hFF, 1)));
    tbl.push_back(mk("t4_idle2",  16'h0000, 0, 0, pack(0, 0, 10, 8'hFF, 1)));
    foreach (tbl[i]) begin
      drive(tbl[i].src, tbl[i].rdy, tbl[i].ack);
      tick();
      chk(tbl[i].name, dut_pack(), tbl[i].exp);
    end

    // Withdrawal by kill_ack; withdrawn source stays pending.
    reach_kill("t2");
    drive('0, 0, 1); tick();
    chk("t2_withdrawn", dut_pack(), pack(0, 0, 3, 8'h20, 3));
    drive('0, 0, 0); tick();
    chk("t2_settle", dut_pack(), pack(0, 0, 3, 8'h20, 3));
    tick();
    chk("t2_pres7", dut_pack(), pack(1, 0, 7, 8'h80, 3));
    drive('0, 1, 0); tick();
    drive('0, 0, 0); ticks(2);
    chk("t2_pres3_again", dut_pack(), pack(1, 0, 3, 8'h20, 3));
    drive('0, 1, 0); tick();
    drive('0, 0, 0); ticks(4);
    chk("t2_quiet", dut_pack(), pack(0, 0, 3, 8'h20, 3));

    // Ready and kill_ack together: accept wins and src 3 is consumed.
    reach_kill("t3");
    drive('0, 1, 1); tick();
    chk("t3_accept", dut_pack(), pack(0, 0, 3, 8'h20, 3));
    drive('0, 0, 0); ticks(2);
    chk("t3_pres7", dut_pack(), pack(1, 0, 7, 8'h80, 3));
    drive('0, 1, 0); tick();
    drive('0, 0, 0); ticks(4);
    chk("t3_no_src3", dut_pack(), pack(0, 0, 7, 8'h80, 3));

    // Level source re-presents while held, is withdrawn when dropped.
    drive(16'h0010, 0, 0); ticks(3);
    chk("t5_pres4", dut_pack(), pack(1, 0, 4, 8'h30, 3));
    drive(16'h0010, 1, 0); tick();
    chk("t5_acc", dut_pack(), pack(0, 0, 4, 8'h30, 3));
    drive(16'h0010, 0, 0); tick();
    chk("t5_settle", dut_pack(), pack(0, 0, 4, 8'h30, 3));
    tick();
    chk("t5_repres", dut_pack(), pack(1, 0, 4, 8'h30, 3));
    drive('0, 0, 0); tick();
    chk("t5_drop_nokill", dut_pack(), pack(1, 0, 4, 8'h30, 3));
    tick();
    chk("t5_drop_kill", dut_pack(), pack(1, 1, 4, 8'h30, 3));
    drive('0, 0, 1); tick();
    chk("t5_withdrawn", dut_pack(), pack(0, 0, 4, 8'h30, 3));
    drive('0, 0, 0); ticks(4);
    chk("t5_quiet", dut_pack(), pack(0, 0, 4, 8'h30, 3));

    // Asynchronous reset in KILL clears everything at once.
    reach_kill("t6");
    #1 rst_n = 0;
    #1 chk("t6_async_reset", dut_pack(), pack(0, 0, 0, 0, 0));
    @(posedge clk); #1 rst_n = 1;
    ticks(4);
    chk("t6_no_pres", dut_pack(), pack(0, 0, 0, 0, 0));
    drive(16'h0020, 0, 0); tick();
    drive('0, 0, 0); ticks(2);
    chk("t6_new_edge", dut_pack(), pack(1, 0, 5, 8'h40, 3));
    drive('0, 1, 0); tick();
    drive('0, 0, 0);

    // Random phase against the reference model.
    rst_n = 0; ticks(2); rst_n = 1;
    model_reset();
    model_on = 1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        for (int i = 0; i < N; i++) begin
          edg[i] = 1'($urandom_range(0, 1));
          ie[i]  = ($urandom_range(0, 3) != 0);
          lvl[8*i +: 8] = 8'($urandom_range(0, 3) * 8'h40 + 8'h10);
          pr[2*i +: 2]  = 2'($urandom_range(0, 3));
        end
      end
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 49) == 0) ie[i] = ~ie[i];
        if (edg[i]) src[i] = ($urandom_range(0, 19) == 0);
        else if ($urandom_range(0, 14) == 0) src[i] = ~src[i];
      end
      ready = ($urandom_range(0, 3) == 0);
      ack   = ($urandom_range(0, 2) == 0);
      tick();
      chk("random", dut_pack(), pack(m_v, m_k, m_id, m_lvl, m_pr));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
